// File: rtl/mem_pkg.sv
// Shared response record and parameter limits for the pipelined memory port.
package mem_pkg;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 4;
   localparam int DATA_W_MAX  = 128;

   // Data is zero-extended to DATA_W_MAX so one record type serves every DATA_W.
   typedef struct packed {
      logic [DATA_W_MAX-1:0] data;
      logic                  error;
   } resp_t;

endpackage

// File: rtl/resp_fifo.sv
// Response queue for mem_pipe_port: N entries, pointers wrap modulo N.
module resp_fifo
   import mem_pkg::*;
#(
   parameter int N     = 2,
   parameter int CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  resp_t            push_rec,
   input  logic             pop,
   output resp_t            head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   resp_t            ram_q [N];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(N - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = push ? bump(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? bump(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) ram_q[wr_ptr_q] <= push_rec;
   end

   assign head  = ram_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/mem_pipe_port.sv
// Single-port memory with handshake, LATENCY-stage response pipeline and a
// flow-controlled response queue; optional read-only instruction mode.
module mem_pipe_port
   import mem_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 256,
   parameter int LATENCY   = 1,
   parameter int INSTR_MEM = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                request,
   output logic                ready,
   input  logic                we_re,
   input  logic [DATA_W/8-1:0] mask,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                resp_ready,
   output logic                valid,
   output logic [DATA_W-1:0]   data_out,
   output logic                error
);

   localparam int NB     = DATA_W / 8;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FIFO_N = LATENCY + 1;
   localparam int CNT_W  = $clog2(FIFO_N + 1);

   if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX || DATA_W > DATA_W_MAX ||
       (DATA_W % 8) != 0) begin : g_bad_param
      $error("mem_pipe_port: illegal LATENCY or DATA_W");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_data;
   logic              in_range, acc_err, accept, wr_en, pop;
   resp_t             new_rec, out_rec;

   logic              pipe_vld_q [LATENCY];
   logic              pipe_vld_d [LATENCY];
   resp_t             pipe_rec_q [LATENCY];
   resp_t             pipe_rec_d [LATENCY];

   logic              fifo_push, fifo_pop, fifo_empty;
   resp_t             fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   int                inflight, used;

   assign idx      = address[IDX_W-1:0];
   assign in_range = ({1'b0, address} < (ADDR_W+1)'(DEPTH));
   assign acc_err  = !in_range || ((INSTR_MEM != 0) && we_re);
   assign accept   = request && ready;
   assign wr_en    = accept && we_re && !acc_err;
   assign rd_data  = mem_q[idx];

   always_comb begin
      new_rec.error = acc_err;
      new_rec.data  = (acc_err || we_re) ? '0 : DATA_W_MAX'(rd_data);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (mask[b]) mem_q[idx][b*8 +: 8] <= data_in[b*8 +: 8];
         end
      end
   end

   // Idle stages carry a zero record so nothing stale can leak to data_out.
   always_comb begin
      for (int i = 0; i < LATENCY; i++) begin
         pipe_vld_d[i] = 1'b0;
         pipe_rec_d[i] = '0;
      end
      pipe_vld_d[0] = accept;
      pipe_rec_d[0] = accept ? new_rec : '0;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_rec_d[i] = pipe_rec_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_rec_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_vld_q[i] <= pipe_vld_d[i];
            pipe_rec_q[i] <= pipe_rec_d[i];
         end
      end
   end

   // Last stage falls through to the outputs when the queue is empty, so an
   // unstalled response appears exactly LATENCY cycles after accept.
   assign out_rec   = fifo_empty ? pipe_rec_q[LATENCY-1] : fifo_head;
   assign valid     = !fifo_empty || pipe_vld_q[LATENCY-1];
   assign data_out  = valid ? DATA_W'(out_rec.data) : '0;
   assign error     = valid && out_rec.error;
   assign pop       = valid && resp_ready;
   assign fifo_pop  = pop && !fifo_empty;
   assign fifo_push = pipe_vld_q[LATENCY-1] && !(fifo_empty && resp_ready);

   resp_fifo #(
      .N     (FIFO_N),
      .CNT_W (CNT_W)
   ) u_resp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_rec (pipe_rec_q[LATENCY-1]),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_comb begin
      inflight = 0;
      for (int i = 0; i < LATENCY; i++) inflight += int'(pipe_vld_q[i]);
      used = int'(fifo_count) + inflight - int'(pop);
   end

   assign ready = rst && (used < FIFO_N);

endmodule
